// File: rtl/opnd_seq_if.sv
// Operand-sequencer handshake bundle: control requests in, memory strobes and status out.
// The slave modport is the sequencer side; the master modport is the controller/memory side.
interface opnd_seq_if;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic       mem_ready;
    logic       mem_rd;
    logic [1:0] addr_sel;
    logic       pcinc;
    logic       arload;
    logic       drload;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, mode, abort, mem_ready,
        output mem_rd, addr_sel, pcinc, arload, drload, busy, done, err
    );

    modport master (
        output start, mode, abort, mem_ready,
        input  mem_rd, addr_sel, pcinc, arload, drload, busy, done, err
    );
endinterface

// File: rtl/opnd_seq.sv
// Operand fetch sequencer: walks immediate/direct/indirect fetches over a shared memory bus,
// with a per-access ready timeout, synchronous abort and asynchronous active-low reset.
module opnd_seq #(
    parameter int TMO = 15
) (
    input  logic        clk,
    input  logic        rst,
    opnd_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_IMM, S_ADR, S_IND, S_DAT, S_DONE, S_ERR
    } state_t;

    localparam logic [3:0] TMO_C = 4'(TMO);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;

    logic       mem_rd, pcinc, arload, drload, busy, done, err;
    logic [1:0] addr_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = 4'd0;
        mode_d   = mode_q;
        mem_rd   = 1'b0;
        addr_sel = 2'b00;
        pcinc    = 1'b0;
        arload   = 1'b0;
        drload   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        busy     = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    unique case (bus.mode)
                        2'b00:   state_d = S_DONE;
                        2'b01:   state_d = S_IMM;
                        default: state_d = S_ADR;
                    endcase
                end
            end
            S_IMM, S_ADR: begin
                mem_rd   = 1'b1;
                addr_sel = 2'b01;
            end
            S_IND, S_DAT: begin
                mem_rd   = 1'b1;
                addr_sel = 2'b10;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Priority: abort, then mem_ready, then timeout. Abort also swallows a pending done/err.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            done    = 1'b0;
            err     = 1'b0;
        end else if (mem_rd) begin
            if (bus.mem_ready) begin
                unique case (state_q)
                    S_IMM: begin
                        drload  = 1'b1;
                        pcinc   = 1'b1;
                        state_d = S_DONE;
                    end
                    S_ADR: begin
                        arload  = 1'b1;
                        pcinc   = 1'b1;
                        state_d = (mode_q == 2'b11) ? S_IND : S_DAT;
                    end
                    S_IND: begin
                        arload  = 1'b1;
                        state_d = S_DAT;
                    end
                    S_DAT: begin
                        drload  = 1'b1;
                        state_d = S_DONE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end else if (cnt_q == TMO_C) begin
                state_d = S_ERR;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign bus.mem_rd   = mem_rd;
    assign bus.addr_sel = addr_sel;
    assign bus.pcinc    = pcinc;
    assign bus.arload   = arload;
    assign bus.drload   = drload;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;
endmodule

// File: tb/tb_opnd_seq.sv
// Bench for opnd_seq: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model (queue of pending memory accesses).
module tb_opnd_seq;
    localparam int TMO = 15;
    localparam int A_IMM = 0, A_ADR = 1, A_IND = 2, A_DAT = 3;

    logic clk;
    logic rst;
    opnd_seq_if bus();

    opnd_seq #(.TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 memory access pending, 2 done, 3 err
    int phase = 0;
    int acc[$];
    int waits = 0;
    int txn = 0;
    int cur_mode = 0;

    always @(negedge clk) begin
        int e_rd, e_sel, e_pc, e_ar, e_dr, e_busy, e_done, e_err, k;
        e_rd = 0; e_sel = 0; e_pc = 0; e_ar = 0; e_dr = 0;
        e_busy = 0; e_done = 0; e_err = 0;
        if (!rst) begin
            phase = 0;
            acc.delete();
            waits = 0;
        end else begin
            if (phase == 2) begin
                e_busy = 1;
                e_done = bus.abort ? 0 : 1;
            end else if (phase == 3) begin
                e_busy = 1;
                e_err  = bus.abort ? 0 : 1;
            end else if (phase == 1) begin
                k      = acc[0];
                e_busy = 1;
                e_rd   = 1;
                e_sel  = (k == A_IMM || k == A_ADR) ? 1 : 2;
                if (!bus.abort && bus.mem_ready) begin
                    e_pc = (k == A_IMM || k == A_ADR) ? 1 : 0;
                    e_ar = (k == A_ADR || k == A_IND) ? 1 : 0;
                    e_dr = (k == A_IMM || k == A_DAT) ? 1 : 0;
                end
            end
        end
        chk("mem_rd",   int'(bus.mem_rd),   e_rd);
        chk("addr_sel", int'(bus.addr_sel), e_sel);
        chk("pcinc",    int'(bus.pcinc),    e_pc);
        chk("arload",   int'(bus.arload),   e_ar);
        chk("drload",   int'(bus.drload),   e_dr);
        chk("busy",     int'(bus.busy),     e_busy);
        chk("done",     int'(bus.done),     e_done);
        chk("err",      int'(bus.err),      e_err);

        if (rst) begin
            case (phase)
                0: if (bus.start) begin
                    cur_mode = int'(bus.mode);
                    acc.delete();
                    case (cur_mode)
                        1: acc.push_back(A_IMM);
                        2: begin acc.push_back(A_ADR); acc.push_back(A_DAT); end
                        3: begin acc.push_back(A_ADR); acc.push_back(A_IND); acc.push_back(A_DAT); end
                        default: ;
                    endcase
                    waits = 0;
                    phase = (acc.size() == 0) ? 2 : 1;
                end
                1: begin
                    if (bus.abort) begin
                        phase = 0;
                        acc.delete();
                        $display("txn %0d mode=%0d aborted", txn++, cur_mode);
                    end else if (bus.mem_ready) begin
                        acc.delete(0);
                        waits = 0;
                        phase = (acc.size() == 0) ? 2 : 1;
                    end else if (waits == TMO) begin
                        phase = 3;
                    end else begin
                        waits++;
                    end
                end
                default: begin
                    $display("txn %0d mode=%0d %s", txn++, cur_mode,
                             (bus.abort ? "aborted" : (phase == 2 ? "done" : "timeout")));
                    phase = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.mode = 2'b00; bus.abort = 1'b0; bus.mem_ready = 1'b0;
    endtask

    int stall;

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("reset_busy",   int'(bus.busy),     0);
        chk("reset_mem_rd", int'(bus.mem_rd),   0);
        chk("reset_sel",    int'(bus.addr_sel), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Immediate: ready on third F_IMM cycle
        bus.start = 1'b1; bus.mode = 2'b01;
        step(); bus.start = 1'b0; bus.mode = 2'b11; #1;
        chk("imm_c1_rd",  int'(bus.mem_rd), 1);
        chk("imm_c1_sel", int'(bus.addr_sel), 1);
        chk("imm_c1_dr",  int'(bus.drload), 0);
        step();
        step(); bus.mem_ready = 1'b1; #1;
        chk("imm_c3_dr", int'(bus.drload), 1);
        chk("imm_c3_pc", int'(bus.pcinc), 1);
        step(); bus.mem_ready = 1'b0; #1;
        chk("imm_done", int'(bus.done), 1);
        chk("imm_done_busy", int'(bus.busy), 1);
        step();
        chk("imm_idle", int'(bus.busy), 0);

        // Indirect with immediate readiness
        bus.start = 1'b1; bus.mode = 2'b11;
        step(); bus.start = 1'b0; bus.mem_ready = 1'b1; #1;
        chk("ind_adr_ar", int'(bus.arload), 1);
        chk("ind_adr_pc", int'(bus.pcinc), 1);
        chk("ind_adr_sel", int'(bus.addr_sel), 1);
        step();
        chk("ind_ind_ar", int'(bus.arload), 1);
        chk("ind_ind_pc", int'(bus.pcinc), 0);
        chk("ind_ind_sel", int'(bus.addr_sel), 2);
        step();
        chk("ind_dat_dr", int'(bus.drload), 1);
        chk("ind_dat_sel", int'(bus.addr_sel), 2);
        step(); bus.mem_ready = 1'b0; #1;
        chk("ind_done", int'(bus.done), 1);
        step();

        // Timeout in F_ADR
        bus.start = 1'b1; bus.mode = 2'b10;
        step(); bus.start = 1'b0; #1;
        for (int i = 0; i < 16; i++) begin
            chk("tmo_wait_rd", int'(bus.mem_rd), 1);
            chk("tmo_wait_err", int'(bus.err), 0);
            step();
        end
        chk("tmo_err", int'(bus.err), 1);
        chk("tmo_err_rd", int'(bus.mem_rd), 0);
        step();
        chk("tmo_idle", int'(bus.busy), 0);

        // Abort with ready in F_DAT
        bus.start = 1'b1; bus.mode = 2'b10;
        step(); bus.start = 1'b0; bus.mem_ready = 1'b1;
        step(); bus.abort = 1'b1; #1;
        chk("abort_dr", int'(bus.drload), 0);
        chk("abort_done", int'(bus.done), 0);
        step(); idle_inputs(); #1;
        chk("abort_idle", int'(bus.busy), 0);

        // Reset in F_IND
        bus.start = 1'b1; bus.mode = 2'b11;
        step(); bus.start = 1'b0; bus.mem_ready = 1'b1;
        step(); bus.mem_ready = 1'b0; #1;
        rst = 1'b0; bus.mem_ready = 1'b1; #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rd", int'(bus.mem_rd), 0);
        chk("rst_ar", int'(bus.arload), 0);
        step(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_busy", int'(bus.busy), 0);
        end
        bus.mem_ready = 1'b0;

        // mode 00: done next cycle, start in DONE ignored
        bus.start = 1'b1; bus.mode = 2'b00;
        step(); #1;
        chk("m0_done", int'(bus.done), 1);
        chk("m0_rd", int'(bus.mem_rd), 0);
        step(); bus.start = 1'b0; #1;
        chk("m0_idle", int'(bus.busy), 0);
        step();

        // Randomized traffic checked by the model every cycle
        stall = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) stall = ($urandom_range(0, 3) == 0) ? 1 : 0;
            bus.start     = ($urandom_range(0, 2) == 0);
            bus.mode      = 2'($urandom_range(0, 3));
            bus.abort     = ($urandom_range(0, 29) == 0);
            bus.mem_ready = (stall == 0) && ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 399) != 0);
            step();
        end
        rst = 1'b1;
        idle_inputs();
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
